// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the mio_bus scratch-RAM arbiter.
// The tie-break policy is selected by MIO_ARB_ROUND_ROBIN_EN.
// With the macro defined, ties alternate between ports.
// With it undefined, port 0 always wins a tie.
package mio_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mio_arb_pick.sv
// Combinational winner select for the two-port RAM arbiter.
// This module holds only the arbitration policy, so the policy can be
// swapped or tested without touching the sequencer.
// MIO_ARB_ROUND_ROBIN_EN: defined = round robin on ties (uses i_last_grant);
// undefined = fixed priority with port 0 winning ties, and no i_last_grant port.
module mio_arb_pick
  import mio_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef MIO_ARB_ROUND_ROBIN_EN
  input  logic i_last_grant,
`endif
  output logic o_gnt_id,
  output logic o_any_req
);

  // Pick the winning port from the live requests.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
    o_gnt_id  = PORT0;
    o_any_req = i_req0 | i_req1;
`ifdef MIO_ARB_ROUND_ROBIN_EN
    if (i_req0 && i_req1) begin
      o_gnt_id = ~i_last_grant;
    end else if (i_req1) begin
      o_gnt_id = PORT1;
    end
`else
    if (i_req1 && !i_req0) begin
      o_gnt_id = PORT1;
    end
`endif
  end

endmodule

// File: rtl/mio_ram_arb.sv
// Two-requester arbiter and sequencer for the single-port mio_ram.
// Port 0 is the CPU data path. Port 1 is a secondary master.
// Each transaction runs IDLE -> ACCESS -> RESP, and its ack follows in the next cycle.
// MIO_ARB_ROUND_ROBIN_EN: defined = round-robin tie-break through r_last_grant;
// undefined = fixed priority to port 0, and r_last_grant does not exist.
module mio_ram_arb
  import mio_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  state_e r_state;
  logic   r_gnt_id;
  logic   w_gnt_id;
  logic   w_any_req;

`ifdef MIO_ARB_ROUND_ROBIN_EN
  logic   r_last_grant;
`endif

  mio_arb_pick u_pick (
    .i_req0       (req0),
    .i_req1       (req1),
`ifdef MIO_ARB_ROUND_ROBIN_EN
    .i_last_grant (r_last_grant),
`endif
    .o_gnt_id     (w_gnt_id),
    .o_any_req    (w_any_req)
  );

  // Sequencer FSM: all RAM controls, acks and read data are registered here.
  // IDLE arbitrates on the live requests. A requester that sees its ack must
  // update or drop its fields in that same cycle.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every branch reads the pre-edge values.
    if (rst) begin
      r_state  <= IDLE;
      r_gnt_id <= PORT0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      ram_we   <= 1'b0;
      ram_a    <= '0;
      ram_d    <= '0;
      busy     <= 1'b0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      ram_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt_id <= w_gnt_id;
            ram_a    <= (w_gnt_id == PORT1) ? addr1  : addr0;
            ram_d    <= (w_gnt_id == PORT1) ? wdata1 : wdata0;
            ram_we   <= (w_gnt_id == PORT1) ? we1    : we0;
            r_state  <= ACCESS;
            busy     <= 1'b1;
          end
        end
        ACCESS: begin
          r_state <= RESP;
        end
        RESP: begin
          if (r_gnt_id == PORT1) begin
            rdata1 <= ram_q;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= ram_q;
            ack0   <= 1'b1;
          end
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIO_ARB_ROUND_ROBIN_EN
  // Remember the last served port. It starts at port 1, so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT1;
    end else if (r_state == RESP) begin
      r_last_grant <= r_gnt_id;
    end
  end
`endif

endmodule

// File: tb/tb_mio_ram_arb.sv
// Directed testbench for mio_ram_arb with a behavioural read-first 64x32 RAM.
// Contention expectations follow MIO_ARB_ROUND_ROBIN_EN.
module tb_mio_ram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        ram_we;
  logic [5:0]  ram_a;
  logic [31:0] ram_d;
  logic [31:0] ram_q;
  logic        busy;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Single-port synchronous RAM: data is valid the cycle after the address, with the old word on a write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  mio_ram_arb dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .we0    (we0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .ack0   (ack0),
    .rdata0 (rdata0),
    .req1   (req1),
    .we1    (we1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .ack1   (ack1),
    .rdata1 (rdata1),
    .ram_we (ram_we),
    .ram_a  (ram_a),
    .ram_d  (ram_d),
    .ram_q  (ram_q),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on one port. The request drops in the same cycle as the ack.
  task automatic do_txn(input logic port, input logic we, input logic [5:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output int we_cnt, output logic [5:0] we_addr, output logic [31:0] we_data);
    bit done = 0;
    rd = '0; lat = 0; we_cnt = 0; we_addr = '0; we_data = '0;
    if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    for (int i = 1; i <= 10 && !done; i++) begin
      tick();
      if (ram_we) begin we_cnt++; we_addr = ram_a; we_data = ram_d; end
      if (port ? ack1 : ack0) begin
        lat = i;
        rd = port ? rdata1 : rdata0;
        done = 1;
      end
    end
    if (port) req1 = 0; else req0 = 0;
    if (!done) check("txn_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [5:0]  wa;
    logic [31:0] wdat;
    int lat, wc, cnt, n_ack, n_ack1, last_tick, bsy_low;
    int ack_t0, ack_t1;
    bit overlap;
    logic [5:0] ra_seq [3];
    int ack_ticks [3];
    logic seq [8];

    rst = 1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tick(); tick();
    // Reset state.
    check("rst_ack0",   32'(ack0),   32'd0);
    check("rst_ack1",   32'(ack1),   32'd0);
    check("rst_rdata0", rdata0,      32'd0);
    check("rst_rdata1", rdata1,      32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_a",  32'(ram_a),  32'd0);
    check("rst_ram_d",  ram_d,       32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    rst = 0;
    tick();

    // Single write, then read back.
    do_txn(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, rd, lat, wc, wa, wdat);
    check("wr5_lat",    32'(lat), 32'd3);
    check("wr5_wecnt",  32'(wc),  32'd1);
    check("wr5_ram_a",  32'(wa),  32'd5);
    check("wr5_ram_d",  wdat,     32'hDEADBEEF);
    do_txn(1'b0, 1'b0, 6'd5, 32'h0, rd, lat, wc, wa, wdat);
    check("rd5_lat",    32'(lat), 32'd3);
    check("rd5_wecnt",  32'(wc),  32'd0);
    check("rd5_data",   rd,       32'hDEADBEEF);
    tick();
    check("rd5_hold",   rdata0,   32'hDEADBEEF);
    check("rd5_ackoff", 32'(ack0), 32'd0);

    // Boundary addresses 63 and 0, plus seed words for the contention reads.
    do_txn(1'b0, 1'b1, 6'd63, 32'hA5A50063, rd, lat, wc, wa, wdat);
    check("wr63_ram_a", 32'(wa), 32'd63);
    do_txn(1'b0, 1'b1, 6'd0,  32'h12340000, rd, lat, wc, wa, wdat);
    do_txn(1'b1, 1'b1, 6'd1,  32'h11111111, rd, lat, wc, wa, wdat);
    check("wr1_p1_lat", 32'(lat), 32'd3);
    do_txn(1'b1, 1'b1, 6'd2,  32'h22222222, rd, lat, wc, wa, wdat);
    do_txn(1'b1, 1'b0, 6'd63, 32'h0, rd, lat, wc, wa, wdat);
    check("rd63_data",  rd, 32'hA5A50063);
    do_txn(1'b0, 1'b0, 6'd0,  32'h0, rd, lat, wc, wa, wdat);
    check("rd0_data",   rd, 32'h12340000);

    // Reset during ACCESS of a port 0 write.
    req0 = 1; we0 = 1; addr0 = 6'd7; wdata0 = 32'h77777777;
    tick();
    check("mid_busy_pre", 32'(busy),   32'd1);
    check("mid_we_pre",   32'(ram_we), 32'd1);
    rst = 1; req0 = 0; we0 = 0;
    tick();
    check("mid_ram_we", 32'(ram_we), 32'd0);
    check("mid_busy",   32'(busy),   32'd0);
    check("mid_ack0",   32'(ack0),   32'd0);
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 || ram_we || busy) cnt++;
    end
    check("mid_quiet", 32'(cnt), 32'd0);
    do_txn(1'b0, 1'b0, 6'd5, 32'h0, rd, lat, wc, wa, wdat);
    check("mid_after_lat",  32'(lat), 32'd3);
    check("mid_after_data", rd,       32'hDEADBEEF);

    // Simultaneous reads after reset: port 0 first, port 1 three cycles later.
    rst = 1; tick(); rst = 0;
    req0 = 1; we0 = 0; addr0 = 6'd1;
    req1 = 1; we1 = 0; addr1 = 6'd2;
    ack_t0 = 0; ack_t1 = 0; overlap = 0;
    for (int i = 1; i <= 12 && (req0 || req1); i++) begin
      tick();
      if (ack0 && ack1) overlap = 1;
      if (ack0) begin ack_t0 = i; req0 = 0; check("sim_rdata0", rdata0, 32'h11111111); end
      if (ack1) begin ack_t1 = i; req1 = 0; check("sim_rdata1", rdata1, 32'h22222222); end
    end
    req0 = 0; req1 = 0;
    check("sim_ack0_t", 32'(ack_t0),  32'd3);
    check("sim_ack1_t", 32'(ack_t1),  32'd6);
    check("sim_overlap", 32'(overlap), 32'd0);

    // Sustained contention for 8 transactions. Port 1 was served last, so port 0 starts.
    req0 = 1; we0 = 0; addr0 = 6'd1;
    req1 = 1; we1 = 0; addr1 = 6'd2;
    n_ack = 0; n_ack1 = 0; last_tick = 0;
    for (int i = 1; i <= 40 && n_ack < 8; i++) begin
      tick();
      if (ack0 || ack1) begin
        seq[n_ack] = ack1;
        if (ack1) n_ack1++;
        n_ack++;
        last_tick = i;
      end
    end
    req0 = 0; req1 = 0;
    check("cont_count", 32'(n_ack),     32'd8);
    check("cont_last",  32'(last_tick), 32'd24);
    for (int k = 0; k < 8; k++) begin
`ifdef MIO_ARB_ROUND_ROBIN_EN
      check($sformatf("cont_port%0d", k), 32'(seq[k]), 32'(k % 2));
`else
      check($sformatf("cont_port%0d", k), 32'(seq[k]), 32'd0);
`endif
    end
`ifdef MIO_ARB_ROUND_ROBIN_EN
    check("cont_ack1_n", 32'(n_ack1), 32'd4);
`else
    check("cont_ack1_n", 32'(n_ack1), 32'd0);
`endif
    tick();

    // Back-to-back writes on port 1, with the address advanced on each ack.
    req1 = 1; we1 = 1; addr1 = 6'd10; wdata1 = 32'hB0 + 32'd10;
    n_ack = 0; cnt = 0; bsy_low = 0;
    for (int i = 1; i <= 20 && n_ack < 3; i++) begin
      tick();
      if (i <= 8 && !busy) bsy_low++;
      if (ram_we && cnt < 3) begin ra_seq[cnt] = ram_a; cnt++; end
      if (ack1) begin
        ack_ticks[n_ack] = i;
        n_ack++;
        addr1 = addr1 + 6'd1;
        wdata1 = 32'hB0 + 32'(addr1);
        if (n_ack == 3) req1 = 0;
      end
    end
    req1 = 0; we1 = 0;
    check("b2b_acks",  32'(n_ack), 32'd3);
    check("b2b_wecnt", 32'(cnt),   32'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b_ram_a%0d", k), 32'(ra_seq[k]),    32'(10 + k));
      check($sformatf("b2b_ack_t%0d", k), 32'(ack_ticks[k]), 32'(3 * (k + 1)));
    end
    check("b2b_busy_low", 32'(bsy_low), 32'd2);
    do_txn(1'b0, 1'b0, 6'd11, 32'h0, rd, lat, wc, wa, wdat);
    check("b2b_rd11", rd, 32'hBB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
